seven_seg_display_driver: RTL and testbench

- Downstream stage of the RPN calculator top level.
- Consumes the 16-bit ToDisplay word and drives an 8-digit, multiplexed, common-anode seven-segment display.
- In decimal mode, converts the unsigned value to BCD with a sequential double-dabble engine, one iteration per cycle. In hex mode, displays the raw nibbles.
- Blanks leading zeros and time-multiplexes the anodes.

---
 rtl/seven_seg_display_driver.sv | 138 +++++++++++++
 tb/tb_seven_seg_display_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_display_driver.sv
// Eight-digit multiplexed common-anode seven-segment driver for the RPN calculator.
// Shows the 16-bit result as unsigned decimal (sequential double-dabble) or as 4 hex nibbles.
module seven_seg_display_driver #(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        hex_mode,
  output logic [7:0]  anodes,
  output logic [6:0]  segments,
  output logic        busy,
  output logic        updated
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t           state, state_next;
  logic [15:0]      last_value;
  logic             last_mode;
  logic [19:0]      bcd, bcd_adj;
  logic [15:0]      bin;
  logic [3:0]       iter;
  logic [4:0][3:0]  disp_digits, disp_next;
  logic [CW-1:0]    refresh_cnt;
  logic [2:0]       scan_idx, scan_next;
  logic             refresh_wrap, capture, lit;
  logic [7:0][3:0]  shown;
  logic [7:0]       vis;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  // Converter control. Input changes are only looked at in IDLE, so a
  // half-finished conversion can never reach the display register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_next = state;
    capture    = (state == IDLE) && ((value != last_value) || (hex_mode != last_mode));
    case (state)
      IDLE:    if (capture) state_next = hex_mode ? COMMIT : SHIFT;
      SHIFT:   if (iter == 4'd15) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble correction: add 3 to any BCD nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    disp_next = disp_digits;
    if (state == COMMIT) begin
      if (last_mode) disp_next = {4'h0, last_value};
      else           disp_next = bcd;
    end
  end

  // Scan and blanking are evaluated on next-cycle state so the registered
  // anode/segment outputs line up with the display register and scan index.
  always_comb begin
    refresh_wrap = (refresh_cnt == CW'(REFRESH_CYCLES - 1));
    scan_next    = refresh_wrap ? scan_idx + 3'd1 : scan_idx;
    shown        = {12'h000, disp_next};
    vis          = '0;
    for (int i = 4; i >= 1; i--) vis[i] = vis[i+1] | (shown[i] != 4'h0);
    vis[0]       = 1'b1;
    lit          = vis[scan_next];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_value  <= '0;
      last_mode   <= 1'b0;
      bcd         <= '0;
      bin         <= '0;
      iter        <= '0;
      disp_digits <= '0;
      refresh_cnt <= '0;
      scan_idx    <= '0;
      anodes      <= 8'hFF;
      segments    <= 7'h7F;
      busy        <= 1'b0;
      updated     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state       <= state_next;
      disp_digits <= disp_next;
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + CW'(1);
      scan_idx    <= scan_next;
      busy        <= (state_next != IDLE);
      updated     <= (state == COMMIT);
      anodes      <= lit ? ~(8'b1 << scan_next) : 8'hFF;
      segments    <= lit ? seg_decode(shown[scan_next]) : 7'h7F;
      case (state)
        IDLE: if (capture) begin
          last_value <= value;
          last_mode  <= hex_mode;
          bcd        <= '0;
          bin        <= value;
          iter       <= '0;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          iter       <= iter + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Directed bench for seven_seg_display_driver: expected display images are queued
// when an input is driven and compared when the updated pulse arrives.
module tb_seven_seg_display_driver;

  localparam int R = 4;

  typedef struct packed {
    logic [7:0]      vis;
    logic [7:0][6:0] seg;
  } disp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        hex_mode;
  logic [7:0]  anodes;
  logic [6:0]  segments;
  logic        busy;
  logic        updated;

  int    checks = 0;
  int    errors = 0;
  disp_t sb[$];

  seven_seg_display_driver #(.REFRESH_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .value(value), .hex_mode(hex_mode),
    .anodes(anodes), .segments(segments), .busy(busy), .updated(updated)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[d];
  endfunction

  function automatic disp_t model(input logic [15:0] v, input logic hex);
    disp_t       e;
    logic [3:0]  dg [8];
    logic [15:0] r;
    int          msd;
    for (int i = 0; i < 8; i++) dg[i] = 4'h0;
    r = v;
    if (hex) for (int i = 0; i < 4; i++) dg[i] = v[4*i +: 4];
    else for (int i = 0; i < 5; i++) begin
      dg[i] = 4'(r % 10);
      r     = r / 10;
    end
    msd = 0;
    for (int i = 0; i < 5; i++) if (dg[i] != 4'h0) msd = i;
    for (int i = 0; i < 8; i++) begin
      e.vis[i] = (i <= msd);
      e.seg[i] = e.vis[i] ? ref_seg(dg[i]) : 7'h7F;
    end
    return e;
  endfunction

  // Compare whatever digit is currently lit against the expected image.
  task automatic sample_check(input disp_t e, output int idx);
    idx = -1;
    if (anodes == 8'hFF) check("blank_segments", segments, 7'h7F);
    else begin
      check("one_anode_low", $countones(~anodes), 1);
      for (int i = 7; i >= 0; i--) if (!anodes[i]) idx = i;
      check("digit_visible", e.vis[idx], 1'b1);
      check("digit_segments", segments, e.seg[idx]);
    end
  endtask

  task automatic scan_check(input disp_t e, output int upd_cnt);
    int cnt [8];
    int idx;
    upd_cnt = 0;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    repeat (8 * R) begin
      @(negedge clk);
      if (updated) upd_cnt++;
      sample_check(e, idx);
      if (idx >= 0) cnt[idx]++;
    end
    for (int i = 0; i < 8; i++) check("slot_lit_count", cnt[i], e.vis[i] ? R : 0);
  endtask

  task automatic wait_update(input int exp_busy, input int exp_lat);
    int    n = 0;
    int    b = 0;
    int    idx;
    bit    seen = 1'b0;
    disp_t e;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (busy) b++;
      if (updated) seen = 1'b1;
    end
    check("updated_seen", seen, 1'b1);
    check("update_latency", n, exp_lat);
    check("busy_cycles", b, exp_busy);
    check("scoreboard_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      sample_check(e, idx);
      @(negedge clk);
      check("updated_one_cycle", updated, 1'b0);
      sample_check(e, idx);
    end
  endtask

  initial begin
    int u;
    reset    = 1'b1;
    value    = 16'd0;
    hex_mode = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("reset_anodes", anodes, 8'hFF);
      check("reset_segments", segments, 7'h7F);
      check("reset_busy", busy, 1'b0);
      check("reset_updated", updated, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_anodes", anodes, 8'hFE);
    check("post_reset_segments", segments, 7'b1000000);
    check("post_reset_busy", busy, 1'b0);
    scan_check(model(16'd0, 1'b0), u);
    check("no_update_when_idle", u, 0);

    value = 16'd1234;
    sb.push_back(model(16'd1234, 1'b0));
    wait_update(17, 18);
    scan_check(model(16'd1234, 1'b0), u);

    value = 16'hFFFF;
    sb.push_back(model(16'hFFFF, 1'b0));
    wait_update(17, 18);
    scan_check(model(16'hFFFF, 1'b0), u);

    hex_mode = 1'b1;
    sb.push_back(model(16'hFFFF, 1'b1));
    wait_update(1, 2);
    scan_check(model(16'hFFFF, 1'b1), u);

    value    = 16'd7;
    hex_mode = 1'b0;
    sb.push_back(model(16'd7, 1'b0));
    wait_update(17, 18);
    scan_check(model(16'd7, 1'b0), u);
    check("no_spurious_update", u, 0);

    // A change during SHIFT is held off until the next IDLE cycle.
    value = 16'd100;
    sb.push_back(model(16'd100, 1'b0));
    sb.push_back(model(16'd200, 1'b0));
    repeat (5) @(negedge clk);
    check("busy_mid_conversion", busy, 1'b1);
    value = 16'd200;
    wait_update(12, 13);
    wait_update(16, 17);
    scan_check(model(16'd200, 1'b0), u);

    // Reset in the middle of converting 9999.
    value = 16'd9999;
    repeat (8) @(negedge clk);
    check("busy_before_abort", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_anodes", anodes, 8'hFF);
    check("abort_segments", segments, 7'h7F);
    reset = 1'b0;
    @(negedge clk);
    check("abort_digit0_anodes", anodes, 8'hFE);
    check("abort_digit0_segments", segments, 7'b1000000);
    check("recapture_busy", busy, 1'b1);
    sb.push_back(model(16'd9999, 1'b0));
    wait_update(16, 17);
    scan_check(model(16'd9999, 1'b0), u);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
